// File: rtl/booth_mul_arbiter_if.sv
// Request/response bus between the clients and booth_mul_arbiter.
// master = client side (drives requests, consumes responses),
// slave  = arbiter side.
interface booth_mul_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [2*WIDTH-1:0]     rsp_product;
    logic                   rsp_err;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_product, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_product, rsp_err
    );
endinterface

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: shares one Booth multiplier between N_REQ requesters.
// Round-robin grant, sequences ld -> gap -> ld_PP, waits for the falling edge
// of the multiplier's ld_p strobe and returns the product with the owner id.
// Optional: define BOOTH_ARB_TIMEOUT_EN to abort a BUSY phase after TIMEOUT
// cycles with rsp_err=1 and a zero product.
module booth_mul_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 16,
    parameter int ID_W    = $clog2(N_REQ),
    parameter int TIMEOUT = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    booth_mul_arbiter_if.slave   bus,
    output logic [WIDTH-1:0]     mul_in_A,
    output logic [WIDTH-1:0]     mul_in_B,
    output logic                 mul_ld,
    output logic                 mul_ld_PP,
    input  logic                 mul_ld_p,
    input  logic [2*WIDTH-1:0]   mul_product,
    output logic                 busy
);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("booth_mul_arbiter: N_REQ must be 2..8 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        GAP    = 3'd2,
        LOADPP = 3'd3,
        BUSY   = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    id_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] product_q;
    logic               err_q;
    logic               ld_p_q;

    logic [ID_W-1:0]    grant;
    logic               grant_found;
    logic [ID_W:0]      idx_sum;
    logic [ID_W-1:0]    idx;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;

    logic               accept;
    logic               done;
    logic               timeout_hit;

    // Round-robin search from rr_ptr upward, plus operand mux for the winner.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        grant       = '0;
        grant_found = 1'b0;
        idx_sum     = '0;
        idx         = '0;
        sel_a       = '0;
        sel_b       = '0;
        // Walk downward so the lowest offset from rr_ptr is written last and wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx_sum >= (ID_W+1)'(N_REQ)) begin
                idx_sum = idx_sum - (ID_W+1)'(N_REQ);
            end
            idx = idx_sum[ID_W-1:0];
            if (bus.req_valid[idx]) begin
                grant       = idx;
                grant_found = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                sel_a = bus.req_a[i*WIDTH +: WIDTH];
                sel_b = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // A request is only taken while idle; a reset cycle never completes a handshake.
    assign accept = (state == IDLE) && grant_found && !reset;
    // Completion is the falling edge of ld_p as seen inside BUSY.
    assign done   = ld_p_q && !mul_ld_p;

`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] busy_cnt;

    // BUSY cycle counter: zero on the first BUSY cycle, +1 per BUSY cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_cnt <= '0;
        end else if (state == LOADPP) begin
            busy_cnt <= '0;
        end else if (state == BUSY) begin
            busy_cnt <= busy_cnt + 1'b1;
        end
    end

    // Fires on the last of TIMEOUT BUSY cycles, so RESP starts TIMEOUT cycles after BUSY entry.
    assign timeout_hit = (state == BUSY) && (busy_cnt == CNT_W'(TIMEOUT - 1)) && !done;

    // Error flag: cleared per transaction, set by an abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_q       = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: fixed load sequence, then wait for completion and the response handshake.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = LOAD;
            LOAD:    state_next = GAP;
            GAP:     state_next = LOADPP;
            LOADPP:  state_next = BUSY;
            BUSY:    if (done || timeout_hit) state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Transaction datapath: operands/id at accept, product while ld_p is high, rr pointer at hand-off.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            product_q <= '0;
            ld_p_q    <= 1'b0;
        end else begin
            // Only strobes seen inside BUSY count toward completion.
            ld_p_q <= (state == BUSY) && mul_ld_p;
            if (accept) begin
                a_q       <= sel_a;
                b_q       <= sel_b;
                id_q      <= grant;
                product_q <= '0;
            end
            if (state == BUSY && mul_ld_p) begin
                product_q <= mul_product;
            end
            if (timeout_hit) begin
                product_q <= '0;
            end
            if (state == RESP && bus.rsp_ready) begin
                rr_ptr <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
            end
        end
    end

    // Output decode from the current state and the transaction registers.
    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[grant] = 1'b1;
        end
        mul_ld          = (state == LOAD);
        mul_ld_PP       = (state == LOADPP);
        mul_in_A        = (state == IDLE) ? '0 : a_q;
        mul_in_B        = (state == IDLE) ? '0 : b_q;
        busy            = (state != IDLE);
        bus.rsp_valid   = (state == RESP);
        bus.rsp_id      = id_q;
        bus.rsp_product = product_q;
        bus.rsp_err     = err_q;
    end

endmodule
